// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, fetch FSM encoding and constants for the fetch stage
package if_fetch_unit_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;
    localparam int FETCH_STATE_LEN = 2;

    typedef enum logic [FETCH_STATE_LEN-1:0] {
        FETCH_S = 2'd0,
        WAIT_S  = 2'd1,
        STALL_S = 2'd2,
        DRAIN_S = 2'd3
    } fetch_state_t;

    localparam logic [INSTRUCTION_LEN-1:0] NOP_INSTRUCTION = '0;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry {pc, instruction} holding register for a response that arrives while frozen
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int INST_W = INSTRUCTION_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_instruction,
    output logic              buf_valid,
    output logic [ADDR_W-1:0] buf_pc,
    output logic [INST_W-1:0] buf_instruction
);

    // Entry register: clear empties it, load captures a new {pc, instruction}
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid       <= 1'b0;
            buf_pc          <= '0;
            buf_instruction <= '0;
        end else if (clear) begin
            buf_valid       <= 1'b0;
            buf_pc          <= '0;
            buf_instruction <= '0;
        end else if (load) begin
            buf_valid       <= 1'b1;
            buf_pc          <= load_pc;
            buf_instruction <= load_instruction;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, memory handshake FSM, skid buffer and IF/ID output registers
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDRESS_LEN,
    parameter int                INST_W   = INSTRUCTION_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_instruction
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] next_seq_pc;
    logic              req_int;

    logic              out_load;
    logic [ADDR_W-1:0] out_load_pc;
    logic [INST_W-1:0] out_load_instruction;

    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_instruction;

    // Instructions are word aligned, so the low address bits of a target are meaningless
    assign branch_target = {branch_addr[ADDR_W-1:2], 2'b00};
    // Sequential successor of the granted fetch; wraps naturally at the top of the address space
    assign next_seq_pc   = fetch_addr_q + ADDR_W'(4);

    assign imem_req  = req_int & rst;
    assign imem_addr = pc_q;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk              (clk),
        .rst              (rst),
        .load             (skid_load),
        .clear            (skid_clear),
        .load_pc          (next_seq_pc),
        .load_instruction (imem_rdata),
        .buf_valid        (skid_valid),
        .buf_pc           (skid_pc),
        .buf_instruction  (skid_instruction)
    );

    // Next-state, PC update and handshake decode; a branch always takes precedence over freeze
    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        fetch_addr_d         = fetch_addr_q;
        req_int              = 1'b0;
        out_load             = 1'b0;
        out_load_pc          = next_seq_pc;
        out_load_instruction = imem_rdata;
        skid_load            = 1'b0;
        skid_clear           = 1'b0;

        case (state_q)
            FETCH_S: begin
                req_int = 1'b1;
                if (imem_gnt) begin
                    fetch_addr_d = pc_q;
                    state_d      = WAIT_S;
                end
                if (branch_taken) begin
                    pc_d = branch_target;
                    // A granted wrong-path request still owes a response that must be swallowed
                    if (imem_gnt) begin
                        state_d = DRAIN_S;
                    end
                end
            end

            WAIT_S: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = imem_rvalid ? FETCH_S : DRAIN_S;
                end else if (imem_rvalid) begin
                    pc_d = next_seq_pc;
                    if (freeze) begin
                        skid_load = 1'b1;
                        state_d   = STALL_S;
                    end else begin
                        out_load = 1'b1;
                        state_d  = FETCH_S;
                    end
                end
            end

            STALL_S: begin
                if (branch_taken) begin
                    skid_clear = 1'b1;
                    pc_d       = branch_target;
                    state_d    = FETCH_S;
                end else if (!freeze) begin
                    out_load             = skid_valid;
                    out_load_pc          = skid_pc;
                    out_load_instruction = skid_instruction;
                    skid_clear           = 1'b1;
                    state_d              = FETCH_S;
                end
            end

            DRAIN_S: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                if (imem_rvalid) begin
                    state_d = FETCH_S;
                end
            end

            default: begin
                state_d = FETCH_S;
            end
        endcase
    end

    // FSM state, program counter and address of the request in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FETCH_S;
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // IF/ID output registers: branch flushes, freeze holds, otherwise present new data or a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instruction <= INST_W'(NOP_INSTRUCTION);
        end else if (branch_taken) begin
            if_valid       <= 1'b0;
            if_instruction <= INST_W'(NOP_INSTRUCTION);
        end else if (freeze) begin
            if_valid       <= if_valid;
        end else if (out_load) begin
            if_valid       <= 1'b1;
            if_pc          <= out_load_pc;
            if_instruction <= out_load_instruction;
        end else begin
            if_valid       <= 1'b0;
            if_instruction <= INST_W'(NOP_INSTRUCTION);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    int n_cmp;
    int n_err;

    if_fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_inst"}, if_instruction, inst);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;

        // reset held for 3 cycles with grant tied high
        tick(); tick(); tick();
        chk_out("reset", 1'b0, 32'h0, 32'h0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);

        // free run: grant immediate, response one cycle later
        rst = 1'b1;
        #1;
        chk("run_req0", {31'd0, imem_req}, 32'd1);
        chk("run_addr0", imem_addr, 32'h0);
        tick();
        chk("run_wait_valid", {31'd0, if_valid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        tick();
        chk_out("run_i0", 1'b1, 32'h4, 32'h11111111);
        chk("run_addr1", imem_addr, 32'h4);
        imem_rvalid = 1'b0;
        tick();
        chk_out("run_bubble", 1'b0, 32'h4, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
        tick();
        chk_out("run_i1", 1'b1, 32'h8, 32'h22222222);
        chk("run_addr2", imem_addr, 32'h8);
        imem_rvalid = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h33333333;
        tick();
        chk_out("run_i2", 1'b1, 32'hC, 32'h33333333);
        imem_rvalid = 1'b0;

        // reset mid-operation, then long latency fetch from 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lat_valid", {31'd0, if_valid}, 32'd0);
            chk("lat_req", {31'd0, imem_req}, 32'd0);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hE3A01005;
        tick();
        chk_out("lat_i", 1'b1, 32'h4, 32'hE3A01005);
        imem_rvalid = 1'b0;

        // freeze for 4 cycles spanning the response
        freeze = 1'b1; imem_gnt = 1'b1;
        tick();
        chk_out("frz_c1", 1'b1, 32'h4, 32'hE3A01005);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE0812002;
        tick();
        chk_out("frz_c2", 1'b1, 32'h4, 32'hE3A01005);
        chk("frz_req2", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick();
        chk("frz_req3", {31'd0, imem_req}, 32'd0);
        tick();
        chk_out("frz_c4", 1'b1, 32'h4, 32'hE3A01005);
        chk("frz_req4", {31'd0, imem_req}, 32'd0);
        freeze = 1'b0;
        tick();
        chk_out("frz_rel", 1'b1, 32'h8, 32'hE0812002);
        chk("frz_addr", imem_addr, 32'h8);

        // branch while waiting on a response
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
        tick();
        chk("brw_valid", {31'd0, if_valid}, 32'd0);
        chk("brw_req", {31'd0, imem_req}, 32'd0);
        branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        chk_out("brw_drop", 1'b0, 32'h8, 32'h0);
        chk("brw_addr", imem_addr, 32'h100);
        chk("brw_req2", {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        tick();
        chk("brw_wait_valid", {31'd0, if_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE59F1004;
        tick();
        chk_out("brw_i", 1'b1, 32'h104, 32'hE59F1004);
        imem_rvalid = 1'b0;

        // branch and freeze together while a response sits in the skid buffer
        freeze = 1'b1; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA5555;
        tick();
        chk_out("stl_hold", 1'b1, 32'h104, 32'hE59F1004);
        chk("stl_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b0; branch_taken = 1'b1; branch_addr = 32'h203;
        tick();
        chk_out("stl_br", 1'b0, 32'h104, 32'h0);
        chk("stl_addr", imem_addr, 32'h200);
        chk("stl_req2", {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0; freeze = 1'b0; imem_gnt = 1'b1;
        tick();
        chk("stl_wait_valid", {31'd0, if_valid}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
        tick();
        chk_out("stl_i", 1'b1, 32'h204, 32'h12345678);
        imem_rvalid = 1'b0;

        // wrap: retarget an ungranted request to the last word
        branch_taken = 1'b1; branch_addr = 32'hFFFFFFFC;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
        chk("wrap_valid", {31'd0, if_valid}, 32'd0);
        branch_taken = 1'b0; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
        tick();
        chk_out("wrap_i", 1'b1, 32'h0, 32'hCAFEF00D);
        chk("wrap_next", imem_addr, 32'h0);

        // stray response in FETCH without a grant is ignored
        tick();
        chk_out("stray", 1'b0, 32'h0, 32'h0);
        chk("stray_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b0;

        // branch coincident with a grant drains the wrong-path response
        branch_taken = 1'b1; branch_addr = 32'h300; imem_gnt = 1'b1;
        tick();
        chk("drn_req", {31'd0, imem_req}, 32'd0);
        branch_taken = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5A5A5A5A;
        tick();
        chk_out("drn_drop", 1'b0, 32'h0, 32'h0);
        chk("drn_addr", imem_addr, 32'h300);
        chk("drn_req2", {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
